// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcode constants, data word width and the
// state encoding of the data-memory responder FSM.
package mips32_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_LW  = 6'h08;
  localparam logic [5:0] OP_SW  = 6'h09;
  localparam logic [5:0] OP_HLT = 6'h3f;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mips32_dmem_array.sv
// DEPTH x 32 single-clock RAM. The request port owns a word on a same-cycle
// write conflict; the second port serves side-band reads and writes.
module mips32_dmem_array
  import mips32_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_en,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic [WORD_W-1:0] req_rdata,
  input  logic              dbg_we,
  input  logic [AW-1:0]     dbg_addr,
  input  logic [WORD_W-1:0] dbg_wdata,
  output logic [WORD_W-1:0] dbg_rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic              req_wr;

  assign req_wr = req_en & req_we;

  // Contents are deliberately never reset.
  always_ff @(posedge clk1) begin
    if (dbg_we && !(req_wr && (req_addr == dbg_addr))) mem[dbg_addr] <= dbg_wdata;
    if (req_wr) mem[req_addr] <= req_wdata;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      req_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (req_en && !req_we) req_rdata <= mem[req_addr];
      dbg_rdata <= mem[dbg_addr];
    end
  end

endmodule

// File: rtl/mips32_dmem_responder.sv
// Data-memory responder for the MIPS32 MEM stage: one outstanding LW/SW,
// answered LATENCY+1 cycles after accept, plus a side-band fill/dump port.
module mips32_dmem_responder
  import mips32_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              dbg_en,
  input  logic              dbg_we,
  input  logic [9:0]        dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output state_t            dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // Handshakes: a request transfers on a clock edge where req_valid & req_ready,
  // a response on an edge where rsp_valid & rsp_ready; rsp_valid and the
  // response payload stay stable until that edge.
  state_t            state;
  logic [3:0]        cnt;
  logic              ready_q;
  logic              we_q;
  logic              err_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              exec;
  logic [31:0]       arr_rdata;

  assign req_ready = ready_q & ~dbg_en;
  assign accept    = req_valid & req_ready;
  // First RESP cycle performs the array access; rsp_valid rises at its end.
  assign exec      = (state == ST_RESP) & ~rsp_valid;
  assign rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? arr_rdata : 32'h0;
  assign rsp_err   = rsp_valid & err_q;
  assign dbg_state = state;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      rsp_valid <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            err_q   <= (req_addr >= 32'(DEPTH));
            ready_q <= 1'b0;
            if (LATENCY > 0) begin
              state <= ST_WAIT;
              cnt   <= LAT_LOAD;
            end else begin
              state <= ST_RESP;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else cnt <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ready_q   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mips32_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .req_en    (exec & ~err_q),
    .req_we    (we_q),
    .req_addr  (addr_q),
    .req_wdata (wdata_q),
    .req_rdata (arr_rdata),
    .dbg_we    (dbg_en & dbg_we),
    .dbg_addr  (dbg_addr[AW-1:0]),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Bench for mips32_dmem_responder: instance a uses LATENCY=2, instance b LATENCY=0;
// both share the side-band port, clock and reset.
module tb_mips32_dmem_responder;
  import mips32_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        a_req_valid, b_req_valid;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_ready;
  logic        dbg_en, dbg_we;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_wdata;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata, a_dbg_rdata;
  state_t      a_state;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata, b_dbg_rdata;
  state_t      b_state;

  logic [31:0] model_a [1024];
  logic [31:0] model_b [1024];
  logic [32:0] exp_q [$];
  int          checks = 0;
  int          passes = 0;

  always #5 clk1 = ~clk1;

  mips32_dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut_a (
    .clk1(clk1), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .dbg_en(dbg_en), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(a_dbg_rdata), .dbg_state(a_state)
  );

  mips32_dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut_b (
    .clk1(clk1), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .dbg_en(dbg_en), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(b_dbg_rdata), .dbg_state(b_state)
  );

  function automatic logic cur_ready(input bit sel);
    return sel ? b_req_ready : a_req_ready;
  endfunction
  function automatic logic cur_valid(input bit sel);
    return sel ? b_rsp_valid : a_rsp_valid;
  endfunction
  function automatic logic [32:0] cur_rsp(input bit sel);
    return sel ? {b_rsp_err, b_rsp_rdata} : {a_rsp_err, a_rsp_rdata};
  endfunction

  // Side-band write to both arrays (the port is shared).
  task automatic dbg_write(input logic [9:0] addr, input logic [31:0] data);
    @(negedge clk1);
    dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
    @(negedge clk1);
    dbg_en = 1'b0; dbg_we = 1'b0;
    model_a[addr] = data;
    model_b[addr] = data;
  endtask

  // Issue one request on instance a (sel=0) or b (sel=1) and complete it.
  task automatic run_req(input bit sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input bit early,
                         input bit conflict);
    int          n;
    int          lat_exp;
    logic        err;
    logic [32:0] exp;
    logic [32:0] got;
    lat_exp = sel ? 1 : 3;
    @(negedge clk1);
    req_we = we; req_addr = addr; req_wdata = wdata;
    if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    n = 0;
    while (!cur_ready(sel) && n < 20) begin
      @(negedge clk1);
      n++;
    end
    checks++;
    if (!cur_ready(sel)) begin
      $display("FAIL accept_timeout: req_ready=0 for %0d cycles, required 1", n);
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      return;
    end
    passes++;
    err = (addr >= 32'd1024);
    exp = {err, (we || err) ? 32'h0 : (sel ? model_b[addr[9:0]] : model_a[addr[9:0]])};
    if (we && !err) begin
      if (sel) model_b[addr[9:0]] = wdata; else model_a[addr[9:0]] = wdata;
    end
    exp_q.push_back(exp);
    @(negedge clk1);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    rsp_ready = early;
    if (conflict) begin
      dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = addr[9:0]; dbg_wdata = ~wdata;
      model_a[addr[9:0]] = ~wdata;
    end
    n = 0;
    while (!cur_valid(sel) && n < 40) begin
      @(negedge clk1);
      dbg_we = 1'b0;
      n++;
    end
    dbg_we = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (n !== lat_exp) $display("FAIL rsp_latency: got %0d cycles, required %0d", n, lat_exp);
    else passes++;
    if (!cur_valid(sel)) begin
      rsp_ready = 1'b0;
      return;
    end
    got = cur_rsp(sel);
    checks++;
    if (got !== exp) $display("FAIL rsp_data addr=%h: got err/rdata %h, required %h", addr, got, exp);
    else passes++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk1);
      checks++;
      if (!cur_valid(sel) || cur_rsp(sel) !== got || cur_ready(sel) !== 1'b0)
        $display("FAIL rsp_hold cycle %0d: valid=%b rsp=%h ready=%b, required 1/%h/0",
                 i, cur_valid(sel), cur_rsp(sel), cur_ready(sel), got);
      else passes++;
    end
    rsp_ready = 1'b1;
    @(negedge clk1);
    rsp_ready = 1'b0;
    checks++;
    if (cur_valid(sel) !== 1'b0 || cur_ready(sel) !== !dbg_en)
      $display("FAIL after_handshake: valid=%b ready=%b, required 0/%b",
               cur_valid(sel), cur_ready(sel), !dbg_en);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a_req_valid = 0; b_req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; dbg_en = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    checks++;
    if (a_req_ready !== 0 || a_rsp_valid !== 0 || a_rsp_rdata !== 0 || a_rsp_err !== 0 ||
        a_dbg_rdata !== 0 || b_req_ready !== 0 || b_rsp_valid !== 0)
      $display("FAIL reset_values: a ready/valid/rdata/err/dbg=%b/%b/%h/%b/%h b ready/valid=%b/%b, required zeros",
               a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_dbg_rdata, b_req_ready, b_rsp_valid);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk1);
    checks++;
    if (a_req_ready !== 1 || b_req_ready !== 1 || a_state !== ST_IDLE)
      $display("FAIL ready_after_reset: a=%b b=%b state=%0d, required 1/1/IDLE", a_req_ready, b_req_ready, a_state);
    else passes++;
  endtask

  task automatic fill_memory();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk1);
      dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = 10'(i); dbg_wdata = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      model_a[i] = dbg_wdata;
      model_b[i] = dbg_wdata;
    end
    @(negedge clk1);
    dbg_en = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic test_dbg_gate();
    // A side-band write strobe without dbg_en must not land.
    @(negedge clk1);
    dbg_we = 1'b1; dbg_addr = 10'd60; dbg_wdata = 32'hDEAD_0060;
    @(negedge clk1);
    dbg_we = 1'b0;
    @(negedge clk1);
    checks++;
    if (a_dbg_rdata !== model_a[60]) $display("FAIL dbg_we_gated: got %h, required %h", a_dbg_rdata, model_a[60]);
    else passes++;
  endtask

  task automatic test_load();
    dbg_write(10'd120, 32'd123);
    run_req(1'b0, 1'b0, 32'd120, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_store_load();
    run_req(1'b0, 1'b1, 32'd121, 32'd168, 0, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 32'd121, 32'h0, 0, 1'b0, 1'b0);
    @(negedge clk1);
    dbg_addr = 10'd121;
    @(negedge clk1);
    checks++;
    if (a_dbg_rdata !== 32'd168) $display("FAIL dbg_read_121: got %h, required %h", a_dbg_rdata, 32'd168);
    else passes++;
  endtask

  task automatic test_backpressure();
    run_req(1'b0, 1'b0, 32'd120, 32'h0, 5, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 32'd121, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++)
      run_req(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(300, 305)),
              $urandom, 0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_out_of_range();
    int bad;
    run_req(1'b0, 1'b0, 32'd1024, 32'h0, 0, 1'b0, 1'b0);
    run_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0, 1'b0, 1'b0);
    bad = 0;
    @(negedge clk1);
    dbg_addr = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk1);
      if (a_dbg_rdata !== model_a[i]) begin
        if (bad < 4) $display("FAIL dump word %0d: got %h, required %h", i, a_dbg_rdata, model_a[i]);
        bad++;
      end
      dbg_addr = 10'(i + 1);
    end
    checks++;
    if (bad != 0) $display("FAIL dump_total: %0d words differ, required 0", bad);
    else passes++;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk1);
    req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'd77; a_req_valid = 1'b1;
    @(negedge clk1);
    a_req_valid = 1'b0;
    checks++;
    if (a_state !== ST_WAIT) $display("FAIL in_wait: state %0d, required WAIT", a_state);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_rsp_valid !== 0 || a_req_ready !== 0 || a_state !== ST_IDLE)
      $display("FAIL async_reset: valid=%b ready=%b state=%0d, required 0/0/IDLE", a_rsp_valid, a_req_ready, a_state);
    else passes++;
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    dbg_addr = 10'd5;
    @(negedge clk1);
    checks++;
    if (a_dbg_rdata !== model_a[5]) $display("FAIL store_discarded: mem[5]=%h, required %h", a_dbg_rdata, model_a[5]);
    else passes++;
    run_req(1'b0, 1'b0, 32'd5, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_latency_dbg();
    run_req(1'b1, 1'b0, 32'd120, 32'h0, 0, 1'b1, 1'b0);
    @(negedge clk1);
    dbg_en = 1'b1; req_we = 1'b0; req_addr = 32'd50; b_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      checks++;
      if (b_req_ready !== 0 || b_rsp_valid !== 0 || b_state !== ST_IDLE)
        $display("FAIL dbg_blocks_accept: ready=%b valid=%b state=%0d, required 0/0/IDLE",
                 b_req_ready, b_rsp_valid, b_state);
      else passes++;
    end
    b_req_valid = 1'b0; dbg_en = 1'b0;
    run_req(1'b1, 1'b1, 32'd200, 32'hCAFE_0200, 0, 1'b0, 1'b1);
    @(negedge clk1);
    checks++;
    if (b_dbg_rdata !== 32'hCAFE_0200 || a_dbg_rdata !== ~32'hCAFE_0200)
      $display("FAIL conflict: b=%h a=%h, required %h/%h", b_dbg_rdata, a_dbg_rdata, 32'hCAFE_0200, ~32'hCAFE_0200);
    else passes++;
    dbg_en = 1'b0;
    run_req(1'b1, 1'b0, 32'd200, 32'h0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    fill_memory();
    test_dbg_gate();
    test_load();
    test_store_load();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_wait();
    test_zero_latency_dbg();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    checks++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
